syscall_sequencer: RTL and testbench



---
 rtl/syscall_sequencer_if.sv | 24 ++
 rtl/syscall_sequencer.sv | 103 ++++++++++
 tb/tb_syscall_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/syscall_sequencer_if.sv
// Decode-side syscall request and display-sink handshake bundle for syscall_sequencer.
interface syscall_sequencer_if;
  logic        sys_valid;
  logic [31:0] instr_ID;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        sys_ready;
  logic        stall;
  logic        disp_valid;
  logic [31:0] disp_data;
  logic        disp_ready;
  logic        halted;
  logic [15:0] disp_count;

  modport master (
    output sys_valid, instr_ID, rs, rt, disp_ready,
    input  sys_ready, stall, disp_valid, disp_data, halted, disp_count
  );

  modport slave (
    input  sys_valid, instr_ID, rs, rt, disp_ready,
    output sys_ready, stall, disp_valid, disp_data, halted, disp_count
  );
endinterface

// File: rtl/syscall_sequencer.sv
// Syscall controller: buffers display values in a FIFO drained over a valid/ready port,
// and turns exit into drain -> fixed delay -> sticky halted, stalling the pipeline meanwhile.
module syscall_sequencer #(
  parameter int          DEPTH      = 4,
  parameter int          EXIT_DELAY = 5,
  parameter logic [31:0] SYSCALL_ID = 32'd26
) (
  input logic                 clk,
  input logic                 reset,
  syscall_sequencer_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, WAIT, HALTED} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [7:0]    delay_cnt, delay_next;
  logic [15:0]   disp_count_q;

  logic request, is_display, is_exit, fifo_full, fifo_empty;
  logic push, pop, sys_ready_c, stall_c;

  assign request    = bus.sys_valid && (bus.instr_ID == SYSCALL_ID);
  assign is_display = (bus.rs == 32'd1);
  assign is_exit    = (bus.rs == 32'd2);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && bus.disp_ready;

  // Fullness uses the registered count, so a same-cycle pop never makes room for a push.
  always_comb begin
    state_next  = state;
    delay_next  = delay_cnt;
    sys_ready_c = 1'b1;
    stall_c     = 1'b0;
    push        = 1'b0;
    unique case (state)
      RUN: begin
        sys_ready_c = !(request && is_display && fifo_full);
        stall_c     = request && !sys_ready_c;
        if (request && sys_ready_c) begin
          if (is_display) push = 1'b1;
          if (is_exit)    state_next = DRAIN;
        end
      end
      DRAIN: begin
        sys_ready_c = 1'b0;
        stall_c     = 1'b1;
        if (fifo_empty) begin
          delay_next = 8'(EXIT_DELAY);
          state_next = WAIT;
        end
      end
      WAIT: begin
        sys_ready_c = 1'b0;
        stall_c     = 1'b1;
        if (delay_cnt == 8'd0) state_next = HALTED;
        else                   delay_next = delay_cnt - 8'd1;
      end
      HALTED: begin
        sys_ready_c = 1'b0;
        stall_c     = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      delay_cnt    <= 8'd0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      disp_count_q <= 16'd0;
    end else begin
      state     <= state_next;
      delay_cnt <= delay_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (push && disp_count_q != 16'hFFFF) disp_count_q <= disp_count_q + 16'd1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rt;
  end

  assign bus.sys_ready  = sys_ready_c;
  assign bus.stall      = stall_c;
  assign bus.disp_valid = !fifo_empty;
  assign bus.disp_data  = fifo_empty ? 32'd0 : mem[rd_ptr];
  assign bus.halted     = (state == HALTED);
  assign bus.disp_count = disp_count_q;
endmodule

// File: tb/tb_syscall_sequencer.sv
// Scoreboard bench for syscall_sequencer: directed scenarios plus randomized traffic,
// checked against an edge-timeline reference model.
module tb_syscall_sequencer;
  localparam int DEPTH      = 4;
  localparam int EXIT_DELAY = 5;

  logic clk;
  logic reset;
  syscall_sequencer_if bus ();

  syscall_sequencer #(
    .DEPTH      (DEPTH),
    .EXIT_DELAY (EXIT_DELAY),
    .SYSCALL_ID (32'd26)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO occupancy, expected display data, and an edge timeline for exit.
  bit          model_ready = 1'b0;
  int          cyc = 0;
  int          exit_edge = -1;
  int          empty_edge = -1;
  int          m_cnt = 0;
  int          m_count = 0;
  logic [31:0] exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit exp_req();
    return bus.sys_valid && (bus.instr_ID == 32'd26);
  endfunction

  function automatic bit exp_sys_ready();
    if (exit_edge >= 0) return 1'b0;
    return !(exp_req() && bus.rs == 32'd1 && m_cnt == DEPTH);
  endfunction

  function automatic bit exp_stall();
    if (exit_edge >= 0) return 1'b1;
    return exp_req() && !exp_sys_ready();
  endfunction

  function automatic bit exp_halted();
    return (empty_edge >= 0) && (cyc >= empty_edge + EXIT_DELAY + 2);
  endfunction

  always @(posedge clk) begin
    bit acc, popping;
    if (reset) begin
      cyc = 0; exit_edge = -1; empty_edge = -1;
      m_cnt = 0; m_count = 0;
      exp_q.delete();
      model_ready = 1'b1;
    end else if (model_ready) begin
      acc     = exp_req() && exp_sys_ready();
      popping = (m_cnt != 0) && bus.disp_ready;
      cyc++;
      if (acc && bus.rs == 32'd1) begin
        exp_q.push_back(bus.rt);
        m_cnt++;
        if (m_count < 65535) m_count++;
      end
      if (popping) m_cnt--;
      if (acc && bus.rs == 32'd2) exit_edge = cyc;
      if (exit_edge >= 0 && empty_edge < 0 && m_cnt == 0) empty_edge = cyc;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("sys_ready",  {31'd0, bus.sys_ready},  {31'd0, exp_sys_ready()});
      checkOutput("stall",      {31'd0, bus.stall},      {31'd0, exp_stall()});
      checkOutput("halted",     {31'd0, bus.halted},     {31'd0, exp_halted()});
      checkOutput("disp_valid", {31'd0, bus.disp_valid}, {31'd0, (m_cnt != 0)});
      checkOutput("disp_count", {16'd0, bus.disp_count}, 32'(m_count));
      if (bus.disp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("disp_unexpected", 32'd1, 32'd0);
        end else begin
          checkOutput("disp_data", bus.disp_data, exp_q[0]);
          if (bus.disp_ready) void'(exp_q.pop_front());
        end
      end else begin
        checkOutput("disp_data_idle", bus.disp_data, 32'd0);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.sys_valid = 1'b0;
    waitCycles(2);
    reset = 1'b0;
  endtask

  task automatic waitAccept(input int max_wait);
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.sys_ready) break;
      n++;
      if (n >= max_wait) begin
        checkOutput("accept_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.sys_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] id, input logic [31:0] rs_v, input logic [31:0] rt_v);
    bus.sys_valid = v;
    bus.instr_ID  = id;
    bus.rs        = rs_v;
    bus.rt        = rt_v;
  endtask

  task automatic sendReq(input logic [31:0] id, input logic [31:0] rs_v, input logic [31:0] rt_v);
    applyStimulus(1'b1, id, rs_v, rt_v);
    waitAccept(50);
  endtask

  initial begin
    int r;
    logic [31:0] rs_pick;
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
    bus.disp_ready = 1'b1;
    waitCycles(3);
    reset = 1'b0;

    // Single display with an always-ready sink
    sendReq(32'd26, 32'd1, 32'hDEAD_BEEF);
    waitCycles(3);

    // Overfill a blocked FIFO; the fifth display stalls until the sink drains
    bus.disp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) sendReq(32'd26, 32'd1, 32'(i));
    applyStimulus(1'b1, 32'd26, 32'd1, 32'd5);
    waitCycles(3);
    bus.disp_ready = 1'b1;
    waitAccept(20);
    waitCycles(6);

    // Exit with an empty FIFO, then a request while halted
    sendReq(32'd26, 32'd2, 32'd0);
    waitCycles(10);
    applyStimulus(1'b1, 32'd26, 32'd1, 32'h1234);
    waitCycles(3);
    doReset();

    // Exit behind three queued values and a stalled sink
    bus.disp_ready = 1'b0;
    for (int i = 0; i < 3; i++) sendReq(32'd26, 32'd1, 32'hA0 + 32'(i));
    sendReq(32'd26, 32'd2, 32'd0);
    waitCycles(10);
    bus.disp_ready = 1'b1;
    waitCycles(15);
    doReset();

    // Non-syscall and unknown-type syscall are no-ops
    sendReq(32'd7, 32'd2, 32'd0);
    sendReq(32'd26, 32'd9, 32'd0);
    waitCycles(2);

    // Reset during the exit delay, then reset with entries still queued
    sendReq(32'd26, 32'd1, 32'h11);
    sendReq(32'd26, 32'd1, 32'h22);
    sendReq(32'd26, 32'd2, 32'd0);
    waitCycles(4);
    doReset();
    bus.disp_ready = 1'b0;
    for (int i = 0; i < 3; i++) sendReq(32'd26, 32'd1, 32'hC0 + 32'(i));
    doReset();
    bus.disp_ready = 1'b1;
    sendReq(32'd26, 32'd1, 32'h5A5A_0001);
    waitCycles(3);

    // Randomized traffic with occasional resets to recover from exits
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      bus.disp_ready = ($urandom_range(0, 9) < 7);
      if (r < 3) begin
        doReset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 60)      rs_pick = 32'd1;
        else if (r < 63) rs_pick = 32'd2;
        else if (r < 80) rs_pick = 32'd0;
        else             rs_pick = $urandom_range(3, 12);
        applyStimulus($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 40)) : 32'd26,
                      rs_pick, $urandom);
        waitCycles(1);
      end
    end

    bus.sys_valid  = 1'b0;
    bus.disp_ready = 1'b1;
    waitCycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
